// File: rtl/bp_cache_req_arb.sv
// Round-robin arbiter that shares one cache engine among num_chan_p client channels.
// One transaction is outstanding at a time; engine responses are routed back to the owner.
module bp_cache_req_arb #(
    parameter int num_chan_p       = 2,
    parameter int req_width_p      = 128,
    parameter int metadata_width_p = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,

    input  logic [num_chan_p*req_width_p-1:0]      chan_req_i,
    input  logic [num_chan_p-1:0]                  chan_req_v_i,
    output logic [num_chan_p-1:0]                  chan_req_ready_and_o,
    output logic [num_chan_p-1:0]                  chan_req_busy_o,
    input  logic [num_chan_p*metadata_width_p-1:0] chan_metadata_i,
    input  logic [num_chan_p-1:0]                  chan_metadata_v_i,
    output logic [num_chan_p-1:0]                  chan_critical_tag_o,
    output logic [num_chan_p-1:0]                  chan_critical_data_o,
    output logic [num_chan_p-1:0]                  chan_complete_o,

    output logic [req_width_p-1:0]                 req_o,
    output logic                                   req_v_o,
    input  logic                                   req_ready_and_i,
    input  logic                                   req_busy_i,
    output logic [metadata_width_p-1:0]            metadata_o,
    output logic                                   metadata_v_o,
    input  logic                                   critical_tag_i,
    input  logic                                   critical_data_i,
    input  logic                                   complete_i,

    output logic [$clog2(num_chan_p)-1:0]          owner_o,
    output logic                                   owner_v_o,

    output logic [1:0]                             dbg_state_o,
    output logic [$clog2(num_chan_p)-1:0]          dbg_rr_ptr_o
);

    localparam int ptr_w_lp = $clog2(num_chan_p);

    // Handshake rule: a request transfers on the cycle where req_v_o and
    // req_ready_and_i are both 1; the winner's chan_req_ready_and_o mirrors that.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_META = 2'd1,
        ST_BUSY = 2'd2
    } state_e;

    state_e                r_state;
    logic [ptr_w_lp-1:0]   r_rr_ptr;
    logic [ptr_w_lp-1:0]   r_owner;
    logic                  r_owner_v;

    logic [ptr_w_lp-1:0]   w_win;
    logic [ptr_w_lp-1:0]   w_cand;
    logic [ptr_w_lp-1:0]   w_rr_next;
    logic                  w_any;
    logic                  w_grant_v;
    logic                  w_hs;
    int                    w_idx;

    // Scan from highest offset down so the last hit is the first channel after rr_ptr.
    always_comb begin
        w_win  = '0;
        w_any  = 1'b0;
        w_idx  = 0;
        w_cand = '0;
        for (int k = num_chan_p - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= num_chan_p) begin
                w_idx = w_idx - num_chan_p;
            end
            w_cand = ptr_w_lp'(w_idx);
            if (chan_req_v_i[w_cand]) begin
                w_win = w_cand;
                w_any = 1'b1;
            end
        end
        w_rr_next = (int'(w_win) == num_chan_p - 1) ? '0 : w_win + 1'b1;
    end

    assign w_grant_v = (r_state == ST_IDLE) && !req_busy_i && w_any;
    assign w_hs      = w_grant_v && req_ready_and_i;

    assign req_o        = chan_req_i[w_win*req_width_p +: req_width_p];
    assign req_v_o      = w_grant_v;
    assign metadata_o   = chan_metadata_i[r_owner*metadata_width_p +: metadata_width_p];
    assign metadata_v_o = (r_state == ST_META) && chan_metadata_v_i[r_owner];

    always_comb begin
        chan_req_ready_and_o = '0;
        chan_req_busy_o      = '0;
        chan_critical_tag_o  = '0;
        chan_critical_data_o = '0;
        chan_complete_o      = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (w_grant_v && (w_win == ptr_w_lp'(i))) begin
                chan_req_ready_and_o[i] = req_ready_and_i;
            end
            if (r_owner_v && (r_owner == ptr_w_lp'(i))) begin
                chan_critical_tag_o[i]  = critical_tag_i;
                chan_critical_data_o[i] = critical_data_i;
                chan_complete_o[i]      = complete_i;
                chan_req_busy_o[i]      = req_busy_i;
            end else begin
                chan_req_busy_o[i]      = req_busy_i | r_owner_v;
            end
        end
    end

    // Completion wins over a same-cycle metadata valid so the engine is never left owned.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_owner_v <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_owner   <= w_win;
                        r_rr_ptr  <= w_rr_next;
                        r_owner_v <= 1'b1;
                        r_state   <= ST_META;
                    end
                end
                ST_META: begin
                    if (complete_i) begin
                        r_owner_v <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (chan_metadata_v_i[r_owner]) begin
                        r_state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (complete_i) begin
                        r_owner_v <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_owner_v <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign owner_o      = r_owner;
    assign owner_v_o    = r_owner_v;
    assign dbg_state_o  = r_state;
    assign dbg_rr_ptr_o = r_rr_ptr;

endmodule
